// File: rtl/fmul.sv
// fmul: 3-cycle pipelined IEEE-754 binary32 multiplier with flush-to-zero inputs and outputs.
// Define FMUL_ROUND_EN for round-to-nearest-even; without it the product mantissa is truncated.
module fmul (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        valid_in,
  output logic [31:0] result,
  output logic        ready
);

  logic [2:0]        valid_q, valid_d;
  logic [31:0]       result_q, result_d;
  logic              ready_q, ready_d;

  logic              sign1_q, sign1_d;
  logic              zero1_q, zero1_d;
  logic signed [9:0] exp1_q, exp1_d;
  logic [35:0]       prodLo1_q, prodLo1_d;
  logic [35:0]       prodHi1_q, prodHi1_d;

  logic              sign2_q, sign2_d;
  logic              zero2_q, zero2_d;
  logic signed [9:0] exp2_q, exp2_d;
  logic [47:0]       prod2_q, prod2_d;

  logic              sign3_q, sign3_d;
  logic              zero3_q, zero3_d;
  logic signed [9:0] exp3_q, exp3_d;
  logic [22:0]       mant3_q, mant3_d;
`ifdef FMUL_ROUND_EN
  logic              guard3_q, guard3_d;
  logic              sticky3_q, sticky3_d;
  logic              roundUp;
  logic [23:0]       mantRounded;
`endif

  logic [23:0]       man1, man2;
  logic [22:0]       mantFinal;
  logic signed [9:0] expFinal;
  logic [31:0]       packed_res;

  // Stage 1: unpack operands, add biased exponents, form the two 12-bit partial products.
  always_comb begin
    man1      = (op1[30:23] == 8'd0) ? 24'd0 : {1'b1, op1[22:0]};
    man2      = (op2[30:23] == 8'd0) ? 24'd0 : {1'b1, op2[22:0]};
    sign1_d   = op1[31] ^ op2[31];
    zero1_d   = (op1[30:23] == 8'd0) || (op2[30:23] == 8'd0);
    exp1_d    = $signed({2'b00, op1[30:23]}) + $signed({2'b00, op2[30:23]}) - 10'sd127;
    prodLo1_d = 36'(man1) * 36'(man2[11:0]);
    prodHi1_d = 36'(man1) * 36'(man2[23:12]);
  end

  // Stage 2: recombine the partial products into the full 48-bit product.
  always_comb begin
    sign2_d = sign1_q;
    zero2_d = zero1_q;
    exp2_d  = exp1_q;
    prod2_d = ({12'd0, prodHi1_q} << 12) + {12'd0, prodLo1_q};
  end

  // Stage 3: normalise so the leading one sits just above the 23 stored mantissa bits.
  always_comb begin
    sign3_d = sign2_q;
    zero3_d = zero2_q;
    if (prod2_q[47]) begin
      mant3_d = prod2_q[46:24];
      exp3_d  = exp2_q + 10'sd1;
    end else begin
      mant3_d = prod2_q[45:23];
      exp3_d  = exp2_q;
    end
`ifdef FMUL_ROUND_EN
    guard3_d  = prod2_q[47] ? prod2_q[23] : prod2_q[22];
    sticky3_d = prod2_q[47] ? (|prod2_q[22:0]) : (|prod2_q[21:0]);
`endif
  end

  // Output stage: round (or truncate), then clamp to zero / infinity and pack.
  always_comb begin
`ifdef FMUL_ROUND_EN
    roundUp     = guard3_q & (sticky3_q | mant3_q[0]);
    mantRounded = {1'b0, mant3_q} + {23'd0, roundUp};
    mantFinal   = mantRounded[22:0];
    expFinal    = exp3_q + $signed({9'd0, mantRounded[23]});
`else
    mantFinal   = mant3_q;
    expFinal    = exp3_q;
`endif
    if (zero3_q)
      packed_res = {sign3_q, 31'd0};
    else if (expFinal >= 10'sd255)
      packed_res = {sign3_q, 8'hFF, 23'd0};
    else if (expFinal <= 10'sd0)
      packed_res = {sign3_q, 31'd0};
    else
      packed_res = {sign3_q, expFinal[7:0], mantFinal};

    valid_d  = {valid_q[1:0], valid_in};
    ready_d  = valid_q[2];
    result_d = valid_q[2] ? packed_res : result_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q  <= 3'd0;
      ready_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Datapath registers need no reset; the valid chain decides which slots matter.
  always_ff @(posedge clk) begin
    sign1_q   <= sign1_d;
    zero1_q   <= zero1_d;
    exp1_q    <= exp1_d;
    prodLo1_q <= prodLo1_d;
    prodHi1_q <= prodHi1_d;
    sign2_q   <= sign2_d;
    zero2_q   <= zero2_d;
    exp2_q    <= exp2_d;
    prod2_q   <= prod2_d;
    sign3_q   <= sign3_d;
    zero3_q   <= zero3_d;
    exp3_q    <= exp3_d;
    mant3_q   <= mant3_d;
`ifdef FMUL_ROUND_EN
    guard3_q  <= guard3_d;
    sticky3_q <= sticky3_d;
`endif
  end

  assign result = result_q;
  assign ready  = ready_q;

endmodule

// File: tb/tb_fmul.sv
// tb_fmul: directed self-checking bench for the fmul pipelined binary32 multiplier.
// Expected tie-rounding result follows FMUL_ROUND_EN when the bench is built with it.
module tb_fmul;

  logic        clk;
  logic        rstn;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        validIn;
  logic [31:0] result;
  logic        ready;

  int checks   = 0;
  int failures = 0;
  int inIdx;
  int outIdx;
  logic expRdy;
  logic [31:0] sA [4];
  logic [31:0] sB [4];
  logic [31:0] sE [4];

`ifdef FMUL_ROUND_EN
  localparam logic [31:0] TIE_EXP = 32'h3FC00002;
`else
  localparam logic [31:0] TIE_EXP = 32'h3FC00001;
`endif

  fmul dut (
    .clk      (clk),
    .rstn     (rstn),
    .op1      (op1),
    .op2      (op2),
    .valid_in (validIn),
    .result   (result),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic v);
    op1     = a;
    op2     = b;
    validIn = v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated operation: ready must stay low for three edges, strobe once, and result must hold.
  task automatic runSingle(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    applyStimulus(a, b, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      applyStimulus(32'd0, 32'd0, 1'b0);
      checkOutput($sformatf("%s_ready_lo%0d", tag, k), {31'd0, ready}, 32'd0);
    end
    @(negedge clk);
    checkOutput({tag, "_ready"}, {31'd0, ready}, 32'd1);
    checkOutput({tag, "_result"}, result, exp);
    @(negedge clk);
    checkOutput({tag, "_ready_after"}, {31'd0, ready}, 32'd0);
    checkOutput({tag, "_hold"}, result, exp);
  endtask

  initial begin
    rstn = 1'b0;
    applyStimulus(32'd0, 32'd0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rstn = 1'b1;

    runSingle("mul_2x3",     32'h40000000, 32'h40400000, 32'h40C00000);
    runSingle("mul_neg",     32'h3FC00000, 32'hBFC00000, 32'hC0100000);
    runSingle("mul_negzero", 32'h3F800000, 32'h80000000, 32'h80000000);
    runSingle("mul_tie",     32'h3F800001, 32'h3FC00000, TIE_EXP);
    runSingle("mul_ovf",     32'h7F000000, 32'h40000000, 32'h7F800000);
    runSingle("mul_unf",     32'h00800000, 32'h3F000000, 32'h00000000);
    runSingle("mul_denorm",  32'h00000001, 32'h40000000, 32'h00000000);
    runSingle("mul_maxman",  32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    runSingle("mul_negneg",  32'hC0000000, 32'hC0000000, 32'h40800000);

    // Streaming with a one-cycle gap: valid on edges 0,1,2,4 gives ready after edges 3,4,5,7.
    sA[0] = 32'h40000000; sB[0] = 32'h40400000; sE[0] = 32'h40C00000;
    sA[1] = 32'h3FC00000; sB[1] = 32'hBFC00000; sE[1] = 32'hC0100000;
    sA[2] = 32'h7F000000; sB[2] = 32'h40000000; sE[2] = 32'h7F800000;
    sA[3] = 32'h00800000; sB[3] = 32'h3F000000; sE[3] = 32'h00000000;
    inIdx  = 0;
    outIdx = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 0 || c == 1 || c == 2 || c == 4) begin
        applyStimulus(sA[inIdx], sB[inIdx], 1'b1);
        inIdx++;
      end else begin
        applyStimulus(32'd0, 32'd0, 1'b0);
      end
      @(negedge clk);
      expRdy = (c == 3 || c == 4 || c == 5 || c == 7);
      checkOutput($sformatf("stream_ready_c%0d", c), {31'd0, ready}, {31'd0, expRdy});
      if (expRdy) begin
        checkOutput($sformatf("stream_result_c%0d", c), result, sE[outIdx]);
        outIdx++;
      end
    end
    checkOutput("stream_count", outIdx, 32'd4);

    // Reset while two operations are in flight, with valid also asserted during reset.
    for (int c = 0; c < 9; c++) begin
      if (c < 2) begin
        rstn = 1'b1;
        applyStimulus(32'h40000000, 32'h40400000, 1'b1);
      end else if (c == 2) begin
        rstn = 1'b0;
        applyStimulus(32'h3FC00000, 32'h3FC00000, 1'b1);
      end else begin
        rstn = 1'b1;
        applyStimulus(32'd0, 32'd0, 1'b0);
      end
      @(negedge clk);
      checkOutput($sformatf("rst_ready_c%0d", c), {31'd0, ready}, 32'd0);
      if (c >= 2)
        checkOutput($sformatf("rst_result_c%0d", c), result, 32'd0);
    end

    runSingle("post_reset", 32'h40000000, 32'h40400000, 32'h40C00000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fmul.md
# fmul

Pipelined single-precision (IEEE-754 binary32) multiplier for the FPU. It is the multiplicative counterpart of the mantissa divider, uses the same operand packing and the same `ready` result-strobe convention, and splits the 24×24 mantissa product into 12-bit halves across pipeline stages. The block accepts one operation per cycle and returns each result a fixed 3 cycles later. There is no back-pressure.

## Interface
Parameters: none.

Clock and reset (already decided): one clock, `clk`; reset `rstn` is synchronous and active-low.

- `clk`  in  1  rising-edge clock
- `rstn`  in  1  synchronous active-low reset
- `op1`  in  32  multiplicand, binary32
- `op2`  in  32  multiplier, binary32
- `valid_in`  in  1  operands valid; sampled every rising edge
- `result`  out  32  product, binary32; holds its last value while `ready`=0
- `ready`  out  1  one-cycle strobe; `result` is valid in the same cycle

## Operation
Stage 1 (unpack, exponents, partial products):
- sign = `op1[31]` ^ `op2[31]`.
- For each operand, m = {1, frac}.
  - If exp==0 (zero or denormal), the operand is flushed to zero and the zero flag is set.
- e = exp1 + exp2 − 127, held as a 10-bit signed value.
- Partial products: m1 × m2[11:0] and m1 × m2[23:12], each 36 bits, registered.

Stage 2 (sum, normalise):
- P = (hi << 12) + lo, 48 bits.
- If P[47]=1: mantissa = P[46:24], guard = P[23], sticky = |P[22:0], e = e + 1.
- Otherwise: mantissa = P[45:23], guard = P[22], sticky = |P[21:0].

Stage 3 (round, pack):
- Rounding is set by the macro in Configuration.
- If rounding carries out of 23 bits: mantissa = 0, e = e + 1.
- Output selection, in priority order:
  1. Either zero flag set: {sign, 31'b0}.
  2. Final e ≥ 255: {sign, 8'hFF, 23'b0} (infinity).
  3. Final e ≤ 0: {sign, 31'b0}. There are no denormal outputs.
  4. Otherwise: {sign, e[7:0], mantissa}.
- Inputs with exp=255 are not special-cased. They are treated as ordinary finite values.
- There is no NaN generation.

Valid pipeline:
- 3-bit shift register v[2:0]: v[0] ← `valid_in`, v[1] ← v[0], v[2] ← v[1]; `ready` = v[2], registered.
- `result` updates only when the stage-3 valid bit is set.
- Data registers on invalid slots may hold don't-care values.

## Timing
- Latency is 3 cycles. If `valid_in`=1 at edge N, `result` and `ready`=1 appear after edge N+3.
- Throughput is 1 operation per cycle. N consecutive valid inputs produce N consecutive `ready` cycles, in order.
- Gaps in `valid_in` are reproduced exactly in `ready`.
- Reset values: `ready`=0, `result`=32'h0, v[2:0]=0.
- Reset mid-operation: every in-flight operation is dropped and produces no `ready`. Inputs with `valid_in`=1 during reset are ignored.
- First acceptance after release: if `rstn`=1 at edge N and `valid_in`=1, `ready` rises after edge N+3.

## Configuration
Macro: `FMUL_ROUND_EN`.
- Defined: round to nearest, ties to even. Increment the mantissa when guard & (sticky | mantissa[0]).
- Undefined: truncation. guard and sticky are ignored and the stage-3 incrementer is not built. Overflow, underflow and zero rules are unchanged.

## Test plan
- Basic product: 32'h40000000 × 32'h40400000 (2.0 × 3.0), single valid -> exactly 3 cycles later `ready`=1 and `result`=32'h40C00000.
- Sign and normalisation: 32'h3FC00000 × 32'hBFC00000 (1.5 × −1.5) -> 32'hC0100000. Also 32'h3F800000 × 32'h80000000 -> 32'h80000000 (signed zero).
- Rounding tie: 32'h3F800001 × 32'h3FC00000 -> 32'h3FC00002 with `FMUL_ROUND_EN`, 32'h3FC00001 without it.
- Exponent range:
  - 32'h7F000000 × 32'h40000000 -> 32'h7F800000 (overflow to infinity).
  - 32'h00800000 × 32'h3F000000 -> 32'h00000000 (underflow to zero).
  - A denormal input, e.g. 32'h00000001 × 32'h40000000 -> 32'h00000000.
- Streaming: valid on cycles 0, 1, 2 and 4 with the four pairs above -> `ready` high on cycles 3, 4, 5 and 7, low on 6, with results in input order.
- Reset mid-flight: issue valid on cycles 0 and 1, drive `rstn`=0 during cycle 2, release it at cycle 3 -> `ready` stays 0 and `result`=0 through cycle 8.
